ifetch_buf: RTL and testbench

IFETCH_BUF -- requirements
Module: ifetch_buf

---
 rtl/ifetch_buf.sv | 144 ++++++++++++++
 tb/tb_ifetch_buf.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buf.sv
// ----------------------------------------------------------------------------
// ifetch_buf -- instruction fetch buffer
//
// Fetches sequential 32-bit instruction words from instruction memory into
// a small FIFO and presents them, in order, to the core's decode stage.
// A redirect from the core flushes the FIFO and restarts fetching at the
// new word-aligned byte address.
//
// Parameters
//   DEPTH        FIFO entries (power of two, 2..16)
//   PC_W         byte-address width of the fetch PC
//
// Ports
//   clk          clock, all state updates on the rising edge
//   clrn         asynchronous, active-high reset
//   redirect     flush and refetch request from the core
//   redirect_pc  new fetch byte address (low two bits ignored)
//   imem_req     fetch request to instruction memory
//   imem_addr    fetch byte address, valid with imem_req
//   imem_ack     memory accepts the request; imem_rdata valid same cycle
//   imem_rdata   fetched instruction word
//   inst_valid   inst/inst_pc hold a deliverable instruction
//   inst         instruction to decode (zero when nothing is valid)
//   inst_pc      byte address of inst (zero when nothing is valid)
//   inst_ready   core consumes inst this cycle
//
// Build option
//   IFB_BYPASS_EN  when defined, a word fetched while the FIFO is empty is
//                  presented on the inst outputs in the same cycle; if the
//                  core takes it right away it never enters the FIFO.
// ----------------------------------------------------------------------------
module ifetch_buf #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 10
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [PC_W-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0] fetch_pc;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [31:0]     mem_inst [DEPTH];
    logic [PC_W-1:0] mem_pc   [DEPTH];

    logic            fifo_nonempty;
    logic            xfer;
    logic            push;
    logic            pop;

    // Redirect targets are word aligned; the two low address bits are dropped.
    logic [1:0]      redirect_pc_unused_bits;
    assign redirect_pc_unused_bits = redirect_pc[1:0];

    assign fifo_nonempty = (count != '0);

    // Request is held off while full, during a redirect and during reset, so
    // a transfer can never collide with a flush or overflow the FIFO.
    assign imem_req  = (count < CW'(DEPTH)) && !redirect && !clrn;
    assign imem_addr = fetch_pc;
    assign xfer      = imem_req && imem_ack;
    assign pop       = fifo_nonempty && inst_ready;

`ifdef IFB_BYPASS_EN
    logic bypass;
    assign bypass = !fifo_nonempty && xfer;
    // A bypassed word taken by the core this cycle is already delivered.
    assign push   = xfer && !(bypass && inst_ready);
`else
    assign push   = xfer;
`endif

    // NOTE: every output is given a default first so no path through this
    // block leaves a variable unassigned (which would infer a latch).
    always_comb begin
        inst_valid = fifo_nonempty;
        inst       = '0;
        inst_pc    = '0;
        if (fifo_nonempty) begin
            inst    = mem_inst[rd_ptr];
            inst_pc = mem_pc[rd_ptr];
        end
`ifdef IFB_BYPASS_EN
        else if (bypass) begin
            inst_valid = 1'b1;
            inst       = imem_rdata;
            inst_pc    = fetch_pc;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            fetch_pc <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            // Flush wins over any same-cycle pop; push is already blocked
            // because imem_req is low while redirect is high.
            fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (xfer) fetch_pc <= fetch_pc + PC_W'(4);
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; stale contents are
    // never visible because the outputs are masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_buf.sv
// ----------------------------------------------------------------------------
// tb_ifetch_buf -- self-checking bench for ifetch_buf.
// A queue-based reference model tracks the expected fetch PC and the
// in-order list of buffered {word, pc} pairs; every cycle the DUT outputs
// are compared against it. Directed sequences cover the corner cases,
// followed by biased random traffic. Build with +define+IFB_BYPASS_EN to
// check the bypass variant.
// ----------------------------------------------------------------------------
module tb_ifetch_buf;

    localparam int DEPTH = 4;
    localparam int PC_W  = 10;

`ifdef IFB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk;
    logic            clrn;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [PC_W-1:0] inst_pc;
    logic            inst_ready;

    ifetch_buf #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     w;
        logic [PC_W-1:0] pc;
    } ent_t;

    ent_t            mq[$];
    logic [PC_W-1:0] mpc;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model, then advance the model to the next rising edge.
    task automatic step(input logic c, input logic rd, input logic [PC_W-1:0] rpc,
                        input logic ack, input logic [31:0] rdata, input logic rdy);
        int   n;
        logic e_req, e_valid, xf;
        logic [31:0]     e_inst;
        logic [PC_W-1:0] e_pc;
        ent_t e;
        @(negedge clk);
        clrn        = c;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = ack;
        imem_rdata  = rdata;
        inst_ready  = rdy;
        #1;
        if (c) begin
            mq.delete();
            mpc = '0;
        end
        n       = mq.size();
        e_req   = (n < DEPTH) && !rd && !c;
        xf      = e_req && ack;
        e_valid = (n != 0);
        e_inst  = (n != 0) ? mq[0].w  : 32'h0;
        e_pc    = (n != 0) ? mq[0].pc : '0;
        if (BYP && n == 0 && xf) begin
            e_valid = 1'b1;
            e_inst  = rdata;
            e_pc    = mpc;
        end
        check("imem_req",   {31'h0, imem_req},  {31'h0, e_req});
        check("imem_addr",  32'(imem_addr),     32'(mpc));
        check("inst_valid", {31'h0, inst_valid}, {31'h0, e_valid});
        check("inst",       inst,               e_inst);
        check("inst_pc",    32'(inst_pc),       32'(e_pc));
        if (!c) begin
            if (rd) begin
                mq.delete();
                mpc = {rpc[PC_W-1:2], 2'b00};
            end else begin
                if (n != 0 && rdy) void'(mq.pop_front());
                if (xf) begin
                    if (!(BYP && n == 0 && rdy)) begin
                        e.w  = rdata;
                        e.pc = mpc;
                        mq.push_back(e);
                    end
                    mpc = mpc + PC_W'(4);
                end
            end
        end
    endtask

    initial begin
        int ack_pct;
        int rdy_pct;
        clrn        = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;
        mpc         = '0;

        // Reset held: everything zero even with ack/ready asserted.
        step(1, 0, 0, 1, $urandom, 1);
        step(1, 0, 0, 1, $urandom, 1);

        // Streaming from reset: addresses 0,4,8,12...
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, $urandom, 1);

        // Fill to full with consumer stalled, then single pop re-enables req.
        step(0, 1, 10'h000, 1, $urandom, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, $urandom, 0);
        step(0, 0, 0, 0, $urandom, 1);
        step(0, 0, 0, 1, $urandom, 0);
        step(0, 0, 0, 1, $urandom, 1);

        // Redirect with three buffered words: flush, aligned new address.
        step(0, 1, 10'h000, 1, $urandom, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, $urandom, 0);
        step(0, 1, 10'h0A2, 1, $urandom, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, $urandom, 1);

        // PC wrap at the top of the address space.
        step(0, 1, 10'h3FC, 0, $urandom, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, $urandom, 1);

        // One-cycle reset pulse with two words buffered.
        step(0, 1, 10'h100, 1, $urandom, 0);
        step(0, 0, 0, 1, $urandom, 0);
        step(0, 0, 0, 1, $urandom, 0);
        step(1, 0, 0, 1, $urandom, 1);
        step(0, 0, 0, 0, $urandom, 1);
        step(0, 0, 0, 0, $urandom, 1);
        step(0, 0, 0, 1, $urandom, 1);
        step(0, 0, 0, 0, $urandom, 1);

        // count=1 with simultaneous push and pop.
        step(0, 1, 10'h040, 0, $urandom, 0);
        step(0, 0, 0, 1, 32'h1234_5678, 0);
        step(0, 0, 0, 1, 32'h8C41_0004, 1);
        step(0, 0, 0, 0, $urandom, 0);
        step(0, 0, 0, 0, $urandom, 1);

        // count=DEPTH-1 with simultaneous push and pop.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, $urandom, 0);
        step(0, 0, 0, 1, $urandom, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, $urandom, 1);

        // Biased random traffic.
        ack_pct = 50;
        rdy_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                ack_pct = (($urandom % 4) == 0) ? 100 : int'($urandom_range(10, 95));
                rdy_pct = (($urandom % 4) == 0) ? 100 : int'($urandom_range(10, 95));
            end
            step(($urandom % 250) == 0,
                 ($urandom % 25) == 0,
                 PC_W'($urandom),
                 int'($urandom % 100) < ack_pct,
                 $urandom,
                 int'($urandom % 100) < rdy_pct);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
